// File: rtl/tmr_vote_skid.sv
// ---------------------------------------------------------------------------
// tmr_vote_skid
//
// Majority voter for three replicas of a WIDTH-bit word, followed by a
// 2-entry skid buffer. Sits where triplicated logic hands data to a single
// (non-triplicated) consumer. Replica disagreements are reported as a
// one-cycle pulse, a multi-replica pulse, a sticky flag and a saturating
// counter.
//
// Handshake: a word moves across an interface at a rising clk edge where
// valid && ready are both high. The producer holds the word stable while
// valid is high and ready is low. in_ready is a register (no combinational
// path from out_ready).
//
// Optional build macro: TMR_VOTE_SKID_SYNDROME_EN adds the err_syn output
// (2-bit single-replica syndrome).
//
// Parameters:
//   WIDTH  data word width (>=1)
//   CNT_W  error counter width (>=1), saturates at all-ones
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   replica words valid
//   in_ready   block can accept a word this cycle (registered)
//   in_a/b/c   replica words
//   out_valid  voted word available
//   out_ready  consumer accepts word
//   out_data   voted word at the head of the buffer
//   err_clr    synchronous clear of err_cnt / err_sticky
//   err_pulse  word accepted last cycle had a mismatching bit
//   err_multi  that mismatch involved more than one replica
//   err_sticky set on any mismatch, held until err_clr
//   err_cnt    saturating count of mismatching accepted words
//   err_syn    (macro only) 0 none/multi, 1 A, 2 B, 3 C
// ---------------------------------------------------------------------------
module tmr_vote_skid #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             err_clr,
    output logic             err_pulse,
    output logic             err_multi,
    output logic             err_sticky,
`ifdef TMR_VOTE_SKID_SYNDROME_EN
    output logic [1:0]       err_syn,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    // Buffer occupancy is the FSM state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    logic [WIDTH-1:0] voted;
    logic             fa, fb, fc;
    logic             mismatch, multi;
    logic             push, pop;
    logic [1:0]       syn_code;

    // Bitwise majority and per-replica "odd one out" detection.
    assign voted    = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
    assign fa       = |((in_a ^ in_b) & (in_a ^ in_c));
    assign fb       = |((in_b ^ in_a) & (in_b ^ in_c));
    assign fc       = |((in_c ^ in_a) & (in_c ^ in_b));
    assign mismatch = fa | fb | fc;
    assign multi    = (fa & fb) | (fa & fc) | (fb & fc);

    always_comb begin
        syn_code = 2'd0;
        if (mismatch && !multi) begin
            if (fa)      syn_code = 2'd1;
            else if (fb) syn_code = 2'd2;
            else         syn_code = 2'd3;
        end
    end

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q != S_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = head_q;

    // Next-state / buffer data. head_q always holds the oldest entry, so
    // it keeps the last delivered word once the buffer drains.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = voted;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = voted;
                end else if (push) begin
                    skid_d  = voted;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so no push can occur.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Error reporting. A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_pulse  <= 1'b0;
            err_multi  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_pulse <= push && mismatch;
            err_multi <= push && multi;
            if (push && mismatch) begin
                err_sticky <= 1'b1;
                if (err_clr)
                    err_cnt <= CNT_W'(1);
                else if (err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + CNT_W'(1);
            end else if (err_clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end
        end
    end

`ifdef TMR_VOTE_SKID_SYNDROME_EN
    // Syndrome is held until the next accepted word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_syn <= 2'd0;
        else if (push)
            err_syn <= syn_code;
    end
`else
    logic unused_syn;
    assign unused_syn = ^syn_code;
`endif

endmodule

// File: tb/tb_tmr_vote_skid.sv
// ---------------------------------------------------------------------------
// tb_tmr_vote_skid
//
// Directed and random stimulus for tmr_vote_skid (WIDTH=8, CNT_W=4).
// A negedge monitor keeps an expected-word queue and a flag model and
// compares every DUT output each cycle while out of reset.
// ---------------------------------------------------------------------------
module tb_tmr_vote_skid;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             err_clr = 1'b0;
    logic             err_pulse, err_multi, err_sticky;
    logic [CNT_W-1:0] err_cnt;
`ifdef TMR_VOTE_SKID_SYNDROME_EN
    logic [1:0]       err_syn;
`endif

    tmr_vote_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err_clr    (err_clr),
        .err_pulse  (err_pulse),
        .err_multi  (err_multi),
        .err_sticky (err_sticky),
`ifdef TMR_VOTE_SKID_SYNDROME_EN
        .err_syn    (err_syn),
`endif
        .err_cnt    (err_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] model_vote(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] r;
        int ones;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    // Bit k set if replica k (0=A,1=B,2=C) was the odd one out on some bit.
    function automatic logic [2:0] model_faults(input logic [WIDTH-1:0] a, b, c);
        logic [2:0] f;
        f = 3'b000;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i] == c[i] && a[i] != b[i]) f[0] = 1'b1;
            if (a[i] == c[i] && b[i] != a[i]) f[1] = 1'b1;
            if (a[i] == b[i] && c[i] != a[i]) f[2] = 1'b1;
        end
        return f;
    endfunction

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_last   = '0;
    logic             exp_pulse  = 1'b0;
    logic             exp_multi  = 1'b0;
    logic             exp_sticky = 1'b0;
    int               exp_cnt    = 0;
    logic [1:0]       exp_syn    = 2'd0;
    bit               done       = 1'b0;

    always @(negedge clk) begin
        if (!done) begin
            if (!rstn) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_in_ready",  32'(in_ready),  32'd1);
                check("rst_out_data",  32'(out_data),  32'd0);
                check("rst_err_pulse", 32'(err_pulse), 32'd0);
                check("rst_err_multi", 32'(err_multi), 32'd0);
                check("rst_err_sticky",32'(err_sticky),32'd0);
                check("rst_err_cnt",   32'(err_cnt),   32'd0);
                exp_q.delete();
                exp_last   = '0;
                exp_pulse  = 1'b0;
                exp_multi  = 1'b0;
                exp_sticky = 1'b0;
                exp_cnt    = 0;
                exp_syn    = 2'd0;
            end else begin
                logic [2:0] f;
                logic       push, mis, mul;
                check("in_ready",   32'(in_ready),   32'(exp_q.size() < 2));
                check("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
                check("err_pulse",  32'(err_pulse),  32'(exp_pulse));
                check("err_multi",  32'(err_multi),  32'(exp_multi));
                check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
                check("err_cnt",    32'(err_cnt),    32'(exp_cnt));
`ifdef TMR_VOTE_SKID_SYNDROME_EN
                check("err_syn",    32'(err_syn),    32'(exp_syn));
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_on_empty", 32'd1, 32'd0);
                    end else begin
                        exp_last = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(exp_last));
                    end
                end else if (!out_valid) begin
                    check("hold_data", 32'(out_data), 32'(exp_last));
                end
                // Predict the effect of the coming edge.
                push = in_valid && in_ready;
                f    = model_faults(in_a, in_b, in_c);
                mis  = push && (f != 3'b000);
                mul  = push && ($countones(f) >= 2);
                if (push) exp_q.push_back(model_vote(in_a, in_b, in_c));
                exp_pulse = mis;
                exp_multi = mul;
                if (mis) begin
                    exp_sticky = 1'b1;
                    if (err_clr)            exp_cnt = 1;
                    else if (exp_cnt < 15)  exp_cnt = exp_cnt + 1;
                end else if (err_clr) begin
                    exp_sticky = 1'b0;
                    exp_cnt    = 0;
                end
                if (push) begin
                    if (f == 3'b001)      exp_syn = 2'd1;
                    else if (f == 3'b010) exp_syn = 2'd2;
                    else if (f == 3'b100) exp_syn = 2'd3;
                    else                  exp_syn = 2'd0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted (bounded wait).
    task automatic send(input logic [WIDTH-1:0] a, b, c);
        bit accepted;
        accepted = 1'b0;
        in_a = a; in_b = b; in_c = c;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            accepted = in_ready;
            step();
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) step();
        rstn = 1'b1;

        // Idle for 10 cycles: monitor checks nothing changes.
        repeat (10) step();

        // Clean word, mismatch on C, multi-replica mismatch.
        out_ready = 1'b1;
        send(8'hA5, 8'hA5, 8'hA5);
        step();
        send(8'hA5, 8'hA5, 8'h5A);
        step();
        send(8'h01, 8'h02, 8'h00);
        repeat (2) step();

        // Back-pressure: third word held off until the consumer resumes.
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 8'h11, 8'h11);
                send(8'h22, 8'h22, 8'h22);
                send(8'h33, 8'h33, 8'h33);
            end
            begin
                repeat (6) step();
                out_ready = 1'b1;
            end
        join
        repeat (3) step();
        check("drain_bp", 32'(exp_q.size()), 32'd0);

        // Counter saturation, then clear racing a new error, then clear alone.
        for (int i = 0; i < 20; i++) send(8'(i), 8'(i), 8'(i) ^ 8'h80);
        step();
        err_clr = 1'b1;
        send(8'h0F, 8'h4F, 8'h0F);
        err_clr = 1'b0;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        repeat (2) step();

        // Random traffic with random back-pressure and clears.
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] base;
            base      = 8'($urandom_range(0, 255));
            in_a      = ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom_range(1, 255)) : base;
            in_b      = ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom_range(1, 255)) : base;
            in_c      = ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom_range(1, 255)) : base;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            step();
        end
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_rand", 32'(exp_q.size()), 32'd0);

        // Reset mid-transfer: buffered words vanish.
        out_ready = 1'b0;
        send(8'hC3, 8'hC3, 8'hC3);
        send(8'h3C, 8'h3C, 8'h3D);
        #2;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmr_vote_skid.md
Name: tmr_vote_skid

Overview:
- Parametrised successor to the plain single-bit pass-through buffers used in hierarchy triplication tests.
- Accepts three replicas of a WIDTH-bit word under a valid/ready handshake and votes them bitwise by majority.
- Buffers the voted word in a 2-entry skid buffer.
- Reports replica mismatches through a pulse, a sticky flag and a saturating error counter.
- Sits at domain boundaries where triplicated logic feeds non-triplicated logic, e.g. a do_not_triplicate consumer.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 4, error counter width in bits (>=1); saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  replica words valid.
- in_ready  output  1  block can accept a word this cycle.
- in_a  input  WIDTH  replica A.
- in_b  input  WIDTH  replica B.
- in_c  input  WIDTH  replica C.
- out_valid  output  1  voted word available.
- out_ready  input  1  consumer accepts word.
- out_data  output  WIDTH  voted word (head of skid buffer).
- err_clr  input  1  synchronous clear of err_cnt and err_sticky.
- err_pulse  output  1  one-cycle pulse: the word accepted last cycle had at least one mismatching bit.
- err_multi  output  1  one-cycle pulse: mismatches in that word were attributable to more than one replica.
- err_sticky  output  1  set by any mismatch; held until err_clr.
- err_cnt  output  CNT_W  count of accepted words with a mismatch, saturating.

Behaviour:
- Reset (rstn low, asynchronous): buffer emptied; out_valid=0, out_data=0, in_ready=1, err_pulse=0, err_multi=0, err_sticky=0, err_cnt=0.
- Reset deassertion and all other updates are synchronous to clk.
- Accept: in_valid && in_ready at a rising edge.
- Vote: out bit i = (a&b)|(a&c)|(b&c).
- Per-replica fault mask:
  - fa = |(a^b & a^c)
  - fb = |(b^a & b^c)
  - fc = |(c^a & c^b)
- Mismatch = fa|fb|fc. Multi = at least two of fa/fb/fc set.
- Skid buffer: 2 entries, FIFO order, count in {0,1,2}.
  - in_ready = (count<2), registered; no combinational path from out_ready to in_ready.
  - out_valid = (count>0).
  - out_data = oldest entry.
- Latency: word accepted at edge N appears on out_data with out_valid=1 after edge N when the buffer was empty.
- Simultaneous accept and pop: count unchanged; order preserved.
- Full (count=2): in_ready=0 from the following cycle; in_valid ignored.
- Empty: out_valid=0; out_data holds its last value (0 after reset).
- Error flags on an accepted word with mismatch:
  - err_pulse=1 for exactly one cycle after the accept edge.
  - err_multi likewise if Multi.
  - err_sticky<=1.
  - err_cnt<=err_cnt+1 unless already at 2^CNT_W-1 (saturate, no wrap).
- Words not accepted (in_ready=0 or in_valid=0) never affect error state.
- err_clr together with an error-bearing accept in the same cycle: err_cnt<=1, err_sticky<=1 (the new error wins over the clear).
- err_clr alone: err_cnt<=0, err_sticky<=0.
- err_clr never affects buffer contents or err_pulse.
- Reset mid-transfer: buffered words are discarded; no partial output.

Optional Feature:
- Macro: TMR_VOTE_SKID_SYNDROME_EN.
- When defined, adds output port err_syn (2 bits), registered alongside err_pulse:
  - 0 = no mismatch; 1 = A only; 2 = B only; 3 = C only.
  - On a multi-replica fault err_syn=0 and err_multi=1.
  - Holds its value until the next accepted word.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: all outputs 0 except in_ready=1; in_valid=0 for 10 cycles -> no change.
- a=b=c=0xA5, in_valid=1, out_ready=1 -> out_data=0xA5 one cycle later; err_pulse=0; err_cnt=0.
- a=0xA5, b=0xA5, c=0x5A -> out_data=0xA5; err_pulse=1 for one cycle; err_sticky=1; err_cnt=1; err_syn=3 if enabled.
- a=0x01, b=0x02, c=0x00 -> out_data=0x00; err_pulse=1; err_multi=1; err_syn=0 if enabled.
- out_ready=0, push 3 distinct words -> in_ready=0 after 2 accepted; third word held off. Then out_ready=1 -> words emerge in order with none lost.
- 20 consecutive mismatching words, CNT_W=4 -> err_cnt stops at 15. Then err_clr together with a mismatching accept -> err_cnt=1, err_sticky=1.
